lcd_write_enable: RTL and testbench

// - Generates one timed LCD Enable (E) strobe for a 4-bit HD44780-style character LCD, then flags completion.
// - Sits under the LCD nibble/byte/phrase writer. The writer presents data on the LCD bus, and this block

---
 rtl/lcd_write_enable_pkg.sv | 15 +
 rtl/lcd_write_enable_if.sv | 10 +
 rtl/lcd_write_enable.sv | 81 ++++++++
 tb/tb_lcd_write_enable.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_write_enable_pkg.sv
// Shared LCD definitions: strobe FSM state encoding and default E timing at 50 MHz.
package lcd_write_enable_pkg;

  typedef enum logic [1:0] {
    ST_SETUP = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } lcd_e_state_t;

  localparam int unsigned LCD_E_SETUP = 2;
  localparam int unsigned LCD_E_PULSE = 12;
  localparam int unsigned LCD_E_HOLD  = 2;

endpackage

// File: rtl/lcd_write_enable_if.sv
// Enable-strobe outputs seen by the LCD pin driver and the nibble/byte writer.
interface lcd_write_enable_if;

  logic oLCD_Enabled;
  logic rEnableDone;

  modport master (output oLCD_Enabled, output rEnableDone);
  modport slave  (input  oLCD_Enabled, input  rEnableDone);

endinterface

// File: rtl/lcd_write_enable.sv
// One timed LCD E strobe (setup -> E high -> hold) per Reset release, then a level done flag.
module lcd_write_enable
  import lcd_write_enable_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = LCD_E_SETUP,
  parameter int unsigned PULSE_CYCLES = LCD_E_PULSE,
  parameter int unsigned HOLD_CYCLES  = LCD_E_HOLD,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  lcd_write_enable_if.master   bus
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

  lcd_e_state_t     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic             r_e,     w_e_nxt;
  logic             r_done,  w_done_nxt;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= ST_SETUP;
      r_cnt   <= '0;
      r_e     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_e     <= w_e_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // E and done are decided one edge ahead so both outputs come straight from flops.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_e_nxt     = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_PULSE;
          w_e_nxt     = 1'b1;
        end
      end
      ST_PULSE: begin
        w_e_nxt = 1'b1;
        if (r_cnt == PULSE_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_HOLD;
          w_e_nxt     = 1'b0;
        end
      end
      ST_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt_nxt   = r_cnt;
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end
      end
      ST_DONE: begin
        w_cnt_nxt  = r_cnt;
        w_done_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = ST_SETUP;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.oLCD_Enabled = r_e;
  assign bus.rEnableDone  = r_done;

endmodule

// File: tb/tb_lcd_write_enable.sv
// Checks two strobe generators (default timing and 1/1/1 timing) against an edge-count model.
module tb_lcd_write_enable;

  localparam int DS = 2, DP = 12, DH = 2;
  localparam int SS = 1, SP = 1, SH = 1;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  lcd_write_enable_if bus_d ();
  lcd_write_enable_if bus_s ();

  lcd_write_enable dut_d (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_d.master)
  );

  lcd_write_enable #(
    .SETUP_CYCLES (SS),
    .PULSE_CYCLES (SP),
    .HOLD_CYCLES  (SH),
    .CNT_W        (4)
  ) dut_s (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_s.master)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: k = number of high-Reset edges since the last low-Reset edge.
  int k = 0;
  bit k_valid = 1'b0;

  int run_d = 0, run_s = 0;
  logic prev_e_d = 1'b0, prev_e_s = 1'b0;
  int pulses_d = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %b, expected %b (k=%0d)", name, $time, act, exp, k);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge Clock) begin
    if (!Reset) begin
      k = 0;
      k_valid = 1'b1;
    end else if (k_valid && k < 100000) begin
      k = k + 1;
    end
  end

  always @(negedge Clock) begin
    if (k_valid) begin
      check("model_e_d",    bus_d.oLCD_Enabled, (k >= DS && k < DS + DP));
      check("model_done_d", bus_d.rEnableDone,  (k >= DS + DP + DH));
      check("model_e_s",    bus_s.oLCD_Enabled, (k >= SS && k < SS + SP));
      check("model_done_s", bus_s.rEnableDone,  (k >= SS + SP + SH));
      check("overlap_d", bus_d.oLCD_Enabled & bus_d.rEnableDone, 1'b0);
      check("overlap_s", bus_s.oLCD_Enabled & bus_s.rEnableDone, 1'b0);

      if (bus_d.oLCD_Enabled === 1'b1 && prev_e_d !== 1'b1) pulses_d++;
      if (bus_d.oLCD_Enabled === 1'b1) run_d++;
      else begin
        if (prev_e_d === 1'b1 && k == DS + DP) check_int("width_d", run_d, DP);
        run_d = 0;
      end
      if (bus_s.oLCD_Enabled === 1'b1) run_s++;
      else begin
        if (prev_e_s === 1'b1 && k == SS + SP) check_int("width_s", run_s, SP);
        run_s = 0;
      end
      prev_e_d = bus_d.oLCD_Enabled;
      prev_e_s = bus_s.oLCD_Enabled;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic pulse_low(input int n);
    Reset = 1'b0;
    step(n);
    Reset = 1'b1;
  endtask

  task automatic wait_done_d();
    int t;
    t = 0;
    while (bus_d.rEnableDone !== 1'b1 && t < 100) begin
      step(1);
      t++;
    end
    check("wait_done_d", bus_d.rEnableDone, 1'b1);
  endtask

  initial begin
    int p0;

    // Reset low for 3 edges, then release.
    Reset = 1'b0;
    step(3);
    check("rst_e_d",    bus_d.oLCD_Enabled, 1'b0);
    check("rst_done_d", bus_d.rEnableDone,  1'b0);
    check("rst_e_s",    bus_s.oLCD_Enabled, 1'b0);
    Reset = 1'b1;
    step(1);
    check("e1_e_d", bus_d.oLCD_Enabled, 1'b0);
    check("e1_e_s", bus_s.oLCD_Enabled, 1'b1);
    step(1);
    check("e2_e_d", bus_d.oLCD_Enabled, 1'b1);
    check("e2_e_s", bus_s.oLCD_Enabled, 1'b0);
    step(1);
    check("e3_done_s", bus_s.rEnableDone, 1'b1);
    step(10);
    check("e13_e_d", bus_d.oLCD_Enabled, 1'b1);
    step(1);
    check("e14_e_d", bus_d.oLCD_Enabled, 1'b0);
    step(1);
    check("e15_done_d", bus_d.rEnableDone, 1'b0);
    step(1);
    check("e16_done_d", bus_d.rEnableDone, 1'b1);

    // Long hold after done: no second strobe.
    p0 = pulses_d;
    step(100);
    check_int("no_restrobe", pulses_d, p0);
    check("done_held", bus_d.rEnableDone, 1'b1);

    // Abort mid-pulse: reset low at release edge 8.
    pulse_low(1);
    step(7);
    Reset = 1'b0;
    step(1);
    check("abort_e_d",    bus_d.oLCD_Enabled, 1'b0);
    check("abort_done_d", bus_d.rEnableDone,  1'b0);
    Reset = 1'b1;
    step(2);
    check("rerun_e2_d", bus_d.oLCD_Enabled, 1'b1);
    wait_done_d();

    // Back-to-back strobes.
    p0 = pulses_d;
    repeat (3) begin
      pulse_low(1);
      wait_done_d();
    end
    check_int("b2b_pulses", pulses_d - p0, 3);

    // Random reset pulses of random spacing.
    for (int i = 0; i < 60; i++) begin
      pulse_low($urandom_range(1, 3));
      step($urandom_range(1, 25));
    end
    pulse_low(1);
    wait_done_d();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
